// File: rtl/comp_pkg.sv
// Shared types and constants for the compressor front-end (stream_comp_flag_gen and its FIFO).
package comp_pkg;

  localparam int WORD_WIDTH_DEF = 32;
  localparam int CNT_WIDTH_DEF  = 16;
  localparam logic [4:0] RATIO_ONE = 5'd16;

  typedef enum logic {
    IDLE   = 1'b0,
    IN_PKT = 1'b1
  } state_t;

  typedef logic [CNT_WIDTH_DEF-1:0] cnt_t;

  // Ratios above one (16/16) are meaningless; treat them as "every word zero".
  function automatic logic [4:0] clamp_ratio(input logic [4:0] r);
    return (r > RATIO_ONE) ? RATIO_ONE : r;
  endfunction

endpackage

// File: rtl/stream_sync_fifo.sv
// Show-ahead synchronous FIFO: array storage with a registered read into an output stage,
// plus a bypass so a beat pushed into an empty FIFO appears on rdata the next cycle.
module stream_sync_fifo #(
  parameter int WIDTH = 34,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]      mem_cnt_reg;
  logic             out_valid_reg;
  logic [WIDTH-1:0] out_data_reg;

  logic out_free, mem_empty, bypass, mem_wr, mem_rd;

  assign out_free  = !out_valid_reg || pop;
  assign mem_empty = (mem_cnt_reg == '0);
  assign bypass    = push && out_free && mem_empty;
  assign mem_wr    = push && !bypass;
  assign mem_rd    = out_free && !mem_empty;

  // Occupancy counts the output stage too, so DEPTH beats fit in total.
  assign full  = ({1'b0, mem_cnt_reg} + {{(AW+1){1'b0}}, out_valid_reg}) == (AW+2)'(DEPTH);
  assign empty = !out_valid_reg;
  assign rdata = out_data_reg;

  always_ff @(posedge clk) begin
    if (mem_wr) begin
      mem[wr_ptr_reg] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      mem_cnt_reg   <= '0;
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
    end else begin
      if (mem_wr) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (mem_rd) begin
        rd_ptr_reg    <= rd_ptr_reg + 1'b1;
        out_data_reg  <= mem[rd_ptr_reg];
        out_valid_reg <= 1'b1;
      end else if (bypass) begin
        out_data_reg  <= wdata;
        out_valid_reg <= 1'b1;
      end else if (pop) begin
        out_valid_reg <= 1'b0;
      end
      mem_cnt_reg <= mem_cnt_reg + (AW+1)'(mem_wr) - (AW+1)'(mem_rd);
    end
  end

endmodule

// File: rtl/stream_comp_flag_gen.sv
// Buffers a packet stream, counts all-zero words per packet and pulses a compress decision at eop.
// Optional COMP_FLAG_STAT_EN adds packet / compressible-packet statistics counters.
`ifndef AXI_DATA_WIDTH
`define AXI_DATA_WIDTH 128
`endif

module stream_comp_flag_gen
  import comp_pkg::*;
#(
  parameter int DATA_WIDTH = `AXI_DATA_WIDTH,
  parameter int WORD_WIDTH = WORD_WIDTH_DEF,
  parameter int DEPTH      = 16,
  parameter int CNT_WIDTH  = CNT_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_valid,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_sop,
  input  logic                  s_eop,
  output logic                  s_ready,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_sop,
  output logic                  m_eop,
  input  logic                  m_ready,
  input  logic [4:0]            cfg_ratio,
  output logic                  comp_flag,
  output logic                  comp_flag_valid,
  output logic                  err_sticky
`ifdef COMP_FLAG_STAT_EN
  ,
  output logic [31:0]           stat_pkt_cnt,
  output logic [31:0]           stat_comp_cnt
`endif
);

  localparam int LANES = DATA_WIDTH / WORD_WIDTH;
  localparam int LW    = $clog2(LANES + 1);
  localparam int CMP_W = CNT_WIDTH + 5;

  logic                    fifo_full, fifo_empty, accept, pop;
  logic [DATA_WIDTH+1:0]   fifo_rdata;

  state_t                  state_reg, state_next;
  logic                    start_pkt, proto_err;
  logic [CNT_WIDTH-1:0]    zcnt_reg, tcnt_reg, zcnt_next, tcnt_next;
  logic [4:0]              ratio_q_reg, ratio_next;
  logic                    comp_flag_reg, comp_flag_valid_reg, err_reg, flag_next;

  logic [LANES-1:0]        lane_zero;
  logic [LW-1:0]           zero_lanes;
  logic [CMP_W-1:0]        zcnt_scaled, tcnt_scaled;

  assign s_ready = !fifo_full && !rst;
  assign accept  = s_valid && s_ready;
  assign m_valid = !fifo_empty;
  assign pop     = m_valid && m_ready;
  assign m_sop   = fifo_rdata[DATA_WIDTH+1];
  assign m_eop   = fifo_rdata[DATA_WIDTH];
  assign m_data  = fifo_rdata[DATA_WIDTH-1:0];

  stream_sync_fifo #(
    .WIDTH (DATA_WIDTH + 2),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (accept),
    .wdata ({s_sop, s_eop, s_data}),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    assign lane_zero[gi] = (s_data[gi*WORD_WIDTH +: WORD_WIDTH] == '0);
  end

  always_comb begin
    zero_lanes = '0;
    for (int i = 0; i < LANES; i++) begin
      zero_lanes = zero_lanes + LW'(lane_zero[i]);
    end
  end

  function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] base,
                                                   input logic [CNT_WIDTH:0]   inc);
    logic [CNT_WIDTH+1:0] sum;
    sum = {2'b00, base} + {1'b0, inc};
    if (sum > {2'b00, {CNT_WIDTH{1'b1}}}) begin
      return {CNT_WIDTH{1'b1}};
    end
    return sum[CNT_WIDTH-1:0];
  endfunction

  // A sop beat (or any beat seen while idle) opens a fresh count window.
  always_comb begin
    state_next = state_reg;
    start_pkt  = 1'b0;
    proto_err  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          start_pkt = 1'b1;
          proto_err = !s_sop;
          if (!s_eop) begin
            state_next = IN_PKT;
          end
        end
      end
      IN_PKT: begin
        if (accept) begin
          start_pkt = s_sop;
          proto_err = s_sop;
          if (s_eop) begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign zcnt_next   = sat_add(start_pkt ? '0 : zcnt_reg, (CNT_WIDTH+1)'(zero_lanes));
  assign tcnt_next   = sat_add(start_pkt ? '0 : tcnt_reg, (CNT_WIDTH+1)'(LANES));
  assign ratio_next  = start_pkt ? clamp_ratio(cfg_ratio) : ratio_q_reg;

  // zeros/total >= ratio/16, cross-multiplied to stay in integers.
  assign zcnt_scaled = {1'b0, zcnt_next, 4'b0000};
  assign tcnt_scaled = CMP_W'(tcnt_next) * CMP_W'(ratio_next);
  assign flag_next   = (zcnt_scaled >= tcnt_scaled);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg           <= IDLE;
      zcnt_reg            <= '0;
      tcnt_reg            <= '0;
      ratio_q_reg         <= '0;
      comp_flag_reg       <= 1'b0;
      comp_flag_valid_reg <= 1'b0;
      err_reg             <= 1'b0;
    end else begin
      state_reg           <= state_next;
      comp_flag_valid_reg <= 1'b0;
      if (accept) begin
        zcnt_reg    <= zcnt_next;
        tcnt_reg    <= tcnt_next;
        ratio_q_reg <= ratio_next;
        if (s_eop) begin
          comp_flag_reg       <= flag_next;
          comp_flag_valid_reg <= 1'b1;
        end
      end
      if (proto_err) begin
        err_reg <= 1'b1;
      end
    end
  end

  assign comp_flag       = comp_flag_reg;
  assign comp_flag_valid = comp_flag_valid_reg;
  assign err_sticky      = err_reg;

`ifdef COMP_FLAG_STAT_EN
  logic [31:0] stat_pkt_reg, stat_comp_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_pkt_reg  <= '0;
      stat_comp_reg <= '0;
    end else if (comp_flag_valid_reg) begin
      stat_pkt_reg <= stat_pkt_reg + 32'd1;
      if (comp_flag_reg) begin
        stat_comp_reg <= stat_comp_reg + 32'd1;
      end
    end
  end

  assign stat_pkt_cnt  = stat_pkt_reg;
  assign stat_comp_cnt = stat_comp_reg;
`endif

endmodule
